adrv9001_enable_sequencer: RTL and testbench

Four-channel enable-pin sequencer driving the ADRV9001 RX1/RX2/TX1/TX2 enable pins. It converts per-channel software or DMA requests into enable pulses with programmable setup delay and post-deassert hold guard. Under TDD interlock, a receive and transmit pair sharing an RF port are never active together. It sits directly upstream of the `system` block's `dio_rx0_enable`, `dio_rx1_enable`, `dio_tx0_enable` and `dio_tx1_enable` inputs.

---
 rtl/adrv9001_enable_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_adrv9001_enable_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adrv9001_enable_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : adrv9001_enable_sequencer
// Description : Four-channel enable-pin sequencer for the ADRV9001
//               RX1/RX2/TX1/TX2 enable pins. Turns level requests into enable
//               pulses with a programmable setup delay before assertion and a
//               hold guard after deassertion. Optionally interlocks the RX/TX
//               pair sharing an RF port so both are never active together.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CNT_W        : width of the setup/hold delay counters
// Ports
//   clk          : sequencer clock (single clock domain)
//   rstn         : asynchronous active-low reset
//   req[3:0]     : level requests, [0]=rx1 [1]=rx2 [2]=tx1 [3]=tx2
//   setup_cycles : request-accept to enable-assert delay (all channels)
//   hold_cycles  : post-deassert guard before a channel may restart
//   en[3:0]      : enable pins, registered
//   busy[3:0]    : channel not idle, registered
//   blocked[3:0] : one-cycle pulse per cycle a request is refused
// Build options
//   ADRV9001_ENSEQ_INTERLOCK_EN : when defined, rx1/tx1 and rx2/tx2 are
//                                 mutually exclusive with RX priority; when
//                                 undefined all channels are independent and
//                                 blocked is always 0.
// ============================================================================
module adrv9001_enable_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [3:0]       req,
  input  logic [CNT_W-1:0] setup_cycles,
  input  logic [CNT_W-1:0] hold_cycles,
  output logic [3:0]       en,
  output logic [3:0]       busy,
  output logic [3:0]       blocked
);

  localparam int NCH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_ON    = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  state_t           r_state     [NCH];
  state_t           w_state_nxt [NCH];
  logic [CNT_W-1:0] r_cnt       [NCH];
  logic [CNT_W-1:0] w_cnt_nxt   [NCH];

  logic [3:0] w_refuse;
  logic [3:0] w_en_nxt;
  logic [3:0] w_busy_nxt;
  logic [3:0] w_blk_nxt;
  logic [3:0] r_en;
  logic [3:0] r_busy;
  logic [3:0] r_blocked;

`ifdef ADRV9001_ENSEQ_INTERLOCK_EN
  logic [3:0] w_idle;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_idle[i] = (r_state[i] == ST_IDLE);
    end
  end

  // Refusal condition for a channel that is itself idle and requesting.
  // RX only yields to an active TX partner; TX also yields to a same-cycle
  // RX request so that RX wins a simultaneous start.
  always_comb begin
    w_refuse    = 4'b0000;
    w_refuse[0] = !w_idle[2];
    w_refuse[1] = !w_idle[3];
    w_refuse[2] = !w_idle[0] || req[0];
    w_refuse[3] = !w_idle[1] || req[1];
  end
`else
  assign w_refuse = 4'b0000;
`endif

  // Next-state / next-output logic for all four channels.
  always_comb begin
    w_en_nxt   = 4'b0000;
    w_busy_nxt = 4'b0000;
    w_blk_nxt  = 4'b0000;
    for (int i = 0; i < NCH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_cnt_nxt[i]   = r_cnt[i];

      case (r_state[i])
        ST_IDLE: begin
          if (req[i]) begin
            if (w_refuse[i]) begin
              // Not latched: the request is simply re-evaluated next cycle.
              w_blk_nxt[i] = 1'b1;
            end else begin
              w_cnt_nxt[i] = setup_cycles;
              if (setup_cycles == '0) begin
                w_state_nxt[i] = ST_ON;
              end else begin
                w_state_nxt[i] = ST_SETUP;
              end
            end
          end
        end

        ST_SETUP: begin
          if (!req[i]) begin
            w_state_nxt[i] = ST_IDLE;
            w_cnt_nxt[i]   = '0;
          end else begin
            w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
            // A loaded value of N reaches ON exactly N edges after acceptance.
            if (r_cnt[i] <= CNT_W'(1)) begin
              w_state_nxt[i] = ST_ON;
              w_cnt_nxt[i]   = '0;
            end
          end
        end

        ST_ON: begin
          if (!req[i]) begin
            w_cnt_nxt[i] = hold_cycles;
            if (hold_cycles == '0) begin
              w_state_nxt[i] = ST_IDLE;
            end else begin
              w_state_nxt[i] = ST_HOLD;
            end
          end
        end

        ST_HOLD: begin
          // Requests are ignored until the guard time has elapsed.
          w_cnt_nxt[i] = r_cnt[i] - CNT_W'(1);
          if (r_cnt[i] <= CNT_W'(1)) begin
            w_state_nxt[i] = ST_IDLE;
            w_cnt_nxt[i]   = '0;
          end
        end

        default: begin
          w_state_nxt[i] = ST_IDLE;
          w_cnt_nxt[i]   = '0;
        end
      endcase

      // Outputs are registered from the next state so they change on the
      // same edge as the state itself, with no path from req to the pins.
      w_en_nxt[i]   = (w_state_nxt[i] == ST_ON);
      w_busy_nxt[i] = (w_state_nxt[i] != ST_IDLE);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= ST_IDLE;
        r_cnt[i]   <= '0;
      end
      r_en      <= 4'b0000;
      r_busy    <= 4'b0000;
      r_blocked <= 4'b0000;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_cnt[i]   <= w_cnt_nxt[i];
      end
      r_en      <= w_en_nxt;
      r_busy    <= w_busy_nxt;
      r_blocked <= w_blk_nxt;
    end
  end

  assign en      = r_en;
  assign busy    = r_busy;
  assign blocked = r_blocked;

endmodule
`default_nettype wire

// File: tb/tb_adrv9001_enable_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_adrv9001_enable_sequencer
// Description : Self-checking bench for adrv9001_enable_sequencer. The driver
//               applies one req vector per cycle and queues the hand-derived
//               {en,busy,blocked} expected after the next clock edge; a
//               monitor pops and compares one entry per edge. Expected values
//               follow the ADRV9001_ENSEQ_INTERLOCK_EN build option.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adrv9001_enable_sequencer;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rstn;
  logic [3:0]       req;
  logic [CNT_W-1:0] setup_cycles;
  logic [CNT_W-1:0] hold_cycles;
  logic [3:0]       en;
  logic [3:0]       busy;
  logic [3:0]       blocked;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] exp_q [$];
  string       name_q [$];
  string       scen = "init";
  int          idx = 0;
  logic [11:0] mon_exp;
  string       mon_name;

  always #5 clk = ~clk;

  adrv9001_enable_sequencer #(.CNT_W(CNT_W)) u_dut (
    .clk          (clk),
    .rstn         (rstn),
    .req          (req),
    .setup_cycles (setup_cycles),
    .hold_cycles  (hold_cycles),
    .en           (en),
    .busy         (busy),
    .blocked      (blocked)
  );

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: en/busy/blocked = %b/%b/%b, expected %b/%b/%b",
               nm, act[11:8], act[7:4], act[3:0], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  // Monitor: one expected entry per clock edge, sampled 1 ns after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      check(mon_name, {en, busy, blocked}, mon_exp);
    end
  end

  task automatic push_exp(input logic [3:0] e_en, input logic [3:0] e_busy, input logic [3:0] e_blk);
    exp_q.push_back({e_en, e_busy, e_blk});
    name_q.push_back($sformatf("%s.%0d", scen, idx));
    idx++;
  endtask

  // Drive req for the coming edge and queue the outputs expected after it.
  task automatic step(input logic [3:0] r, input logic [3:0] e_en,
                      input logic [3:0] e_busy, input logic [3:0] e_blk);
    @(posedge clk);
    #2;
    req = r;
    push_exp(e_en, e_busy, e_blk);
  endtask

  task automatic begin_scen(input string s);
    scen = s;
    idx  = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, queue depth %0d, expected 0", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    rstn         = 1'b0;
    req          = 4'b0000;
    setup_cycles = '0;
    hold_cycles  = '0;
    #2;
    check("reset_state", {en, busy, blocked}, 12'h000);

    // Release reset away from the edge; first evaluation at the next edge.
    @(posedge clk);
    #2;
    rstn = 1'b1;
    begin_scen("idle");
    push_exp(4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Single channel, setup=3, hold=2.
    begin_scen("single_rx1");
    setup_cycles = 16'd3;
    hold_cycles  = 16'd2;
    step(4'b0001, 4'b0000, 4'b0001, 4'b0000);
    step(4'b0001, 4'b0000, 4'b0001, 4'b0000);
    step(4'b0001, 4'b0000, 4'b0001, 4'b0000);
    step(4'b0001, 4'b0001, 4'b0001, 4'b0000);
    step(4'b0001, 4'b0001, 4'b0001, 4'b0000);
    step(4'b0001, 4'b0001, 4'b0001, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0001, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0001, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Zero delays: one-cycle request gives a one-cycle enable.
    begin_scen("zero_delay_tx1");
    setup_cycles = 16'd0;
    hold_cycles  = 16'd0;
    step(4'b0100, 4'b0100, 4'b0100, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Simultaneous rx1+tx1 request, setup=1, hold=1.
    begin_scen("simul_port1");
    setup_cycles = 16'd1;
    hold_cycles  = 16'd1;
`ifdef ADRV9001_ENSEQ_INTERLOCK_EN
    step(4'b0101, 4'b0000, 4'b0001, 4'b0100);
    step(4'b0101, 4'b0001, 4'b0001, 4'b0100);
    step(4'b0101, 4'b0001, 4'b0001, 4'b0100);
    step(4'b0100, 4'b0000, 4'b0001, 4'b0100);
    step(4'b0100, 4'b0000, 4'b0000, 4'b0100);
    step(4'b0100, 4'b0000, 4'b0100, 4'b0000);
    step(4'b0100, 4'b0100, 4'b0100, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0100, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
`else
    step(4'b0101, 4'b0000, 4'b0101, 4'b0000);
    step(4'b0101, 4'b0101, 4'b0101, 4'b0000);
    step(4'b0101, 4'b0101, 4'b0101, 4'b0000);
    step(4'b0100, 4'b0100, 4'b0101, 4'b0000);
    step(4'b0100, 4'b0100, 4'b0100, 4'b0000);
    step(4'b0100, 4'b0100, 4'b0100, 4'b0000);
    step(4'b0100, 4'b0100, 4'b0100, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0100, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
`endif

    // tx2 active first, then rx2 requests: RX has no priority over an active TX.
    begin_scen("tx_first_port2");
    setup_cycles = 16'd0;
    hold_cycles  = 16'd0;
`ifdef ADRV9001_ENSEQ_INTERLOCK_EN
    step(4'b1000, 4'b1000, 4'b1000, 4'b0000);
    step(4'b1010, 4'b1000, 4'b1000, 4'b0010);
    step(4'b0010, 4'b0000, 4'b0000, 4'b0010);
    step(4'b0010, 4'b0010, 4'b0010, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
`else
    step(4'b1000, 4'b1000, 4'b1000, 4'b0000);
    step(4'b1010, 4'b1010, 4'b1010, 4'b0000);
    step(4'b0010, 4'b0010, 4'b0010, 4'b0000);
    step(4'b0010, 4'b0010, 4'b0010, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
`endif

    // SETUP abort: setup=5, two-cycle request on rx2.
    begin_scen("setup_abort_rx2");
    setup_cycles = 16'd5;
    step(4'b0010, 4'b0000, 4'b0010, 4'b0000);
    step(4'b0010, 4'b0000, 4'b0010, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // setup=8 loaded, then changed to 1 mid-count: enable still after 8 edges.
    begin_scen("param_change");
    setup_cycles = 16'd8;
    hold_cycles  = 16'd0;
    step(4'b0001, 4'b0000, 4'b0001, 4'b0000);
    step(4'b0001, 4'b0000, 4'b0001, 4'b0000);
    setup_cycles = 16'd1;
    for (int k = 0; k < 6; k++) begin
      step(4'b0001, 4'b0000, 4'b0001, 4'b0000);
    end
    step(4'b0001, 4'b0001, 4'b0001, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // All channels requested, then asynchronous reset mid-operation.
    begin_scen("reset_midop");
    setup_cycles = 16'd1;
    hold_cycles  = 16'd0;
`ifdef ADRV9001_ENSEQ_INTERLOCK_EN
    step(4'b1111, 4'b0000, 4'b0011, 4'b1100);
    step(4'b1111, 4'b0011, 4'b0011, 4'b1100);
    step(4'b1111, 4'b0011, 4'b0011, 4'b1100);
`else
    step(4'b1111, 4'b0000, 4'b1111, 4'b0000);
    step(4'b1111, 4'b1111, 4'b1111, 4'b0000);
    step(4'b1111, 4'b1111, 4'b1111, 4'b0000);
`endif
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("reset_async_immediate", {en, busy, blocked}, 12'h000);
    @(posedge clk);
    #1;
    check("reset_held", {en, busy, blocked}, 12'h000);
    @(posedge clk);
    #2;
    rstn = 1'b1;
    begin_scen("after_reset");
`ifdef ADRV9001_ENSEQ_INTERLOCK_EN
    push_exp(4'b0000, 4'b0011, 4'b1100);
    step(4'b1111, 4'b0011, 4'b0011, 4'b1100);
`else
    push_exp(4'b0000, 4'b1111, 4'b0000);
    step(4'b1111, 4'b1111, 4'b1111, 4'b0000);
`endif
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // Drain the scoreboard with a bounded wait.
    w = 0;
    while (exp_q.size() != 0 && w < 5) begin
      @(posedge clk);
      #3;
      w++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
